// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one req/gnt/rvalid memory port between instruction fetch and the load/store unit
module mem_port_arbiter #(
  parameter int XLEN       = 32,
  parameter int MAX_STARVE = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req_i,
  input  logic [XLEN-1:0]   if_adr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [XLEN-1:0]   if_rdata_o,
  input  logic              flush_i,
  input  logic              lsu_adr_v_i,
  input  logic [XLEN-1:0]   lsu_adr_i,
  input  logic              lsu_is_store_i,
  input  logic [XLEN-1:0]   lsu_store_data_i,
  input  logic [2:0]        lsu_access_size_i,
  output logic              lsu_gnt_o,
  output logic              lsu_rvalid_o,
  output logic [XLEN-1:0]   lsu_load_data_o,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [XLEN-1:0]   mem_adr_o,
  output logic [XLEN/8-1:0] mem_be_o,
  output logic [XLEN-1:0]   mem_wdata_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [XLEN-1:0]   mem_rdata_i
);

  localparam int NB = XLEN / 8;
  localparam int AB = $clog2(NB);
  localparam logic [3:0]    STARVE_MAX = 4'(MAX_STARVE);
  localparam logic [NB-1:0] BE_BYTE    = NB'(1);
  localparam logic [NB-1:0] BE_HALF    = NB'(3);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_RSP  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic            owner_q, owner_d;   // 1 = LSU owns the transaction, 0 = IF
  logic [3:0]      starve_q, starve_d;
  logic            drop_q, drop_d;
  logic            live_q;             // low in the first cycle after reset releases
  logic [XLEN-1:0] adr_q, adr_d;
  logic [XLEN-1:0] wdata_q, wdata_d;
  logic [NB-1:0]   be_q, be_d;
  logic            we_q, we_d;

  logic            out_en;
  logic            accept_win;
  logic            if_ok;
  logic            lsu_win;
  logic            if_win;
  logic            rsp_valid;
  logic            req_active;
  logic [NB-1:0]   lsu_be;
  logic [XLEN-1:0] lsu_wdata;

  function automatic logic [XLEN-1:0] word_adr(input logic [XLEN-1:0] a);
    return {a[XLEN-1:AB], {AB{1'b0}}};
  endfunction

  // Arbitration: LSU first unless IF has lost MAX_STARVE times in a row; a flush blocks IF.
  assign out_en     = !reset && live_q;
  assign accept_win = out_en && ((state_q == S_IDLE) || ((state_q == S_RSP) && mem_rvalid_i));
  assign if_ok      = if_req_i && !flush_i;
  assign lsu_win    = accept_win && lsu_adr_v_i && !(if_ok && (starve_q == STARVE_MAX));
  assign if_win     = accept_win && if_ok && !lsu_win;

  assign if_gnt_o   = if_win;
  assign lsu_gnt_o  = lsu_win;

  // Response routing: a dropped or being-flushed fetch response is swallowed.
  assign rsp_valid       = out_en && (state_q == S_RSP) && mem_rvalid_i;
  assign lsu_rvalid_o    = rsp_valid && owner_q;
  assign if_rvalid_o     = rsp_valid && !owner_q && !drop_q && !flush_i;
  assign if_rdata_o      = (out_en && (state_q == S_RSP) && !owner_q) ? mem_rdata_i : '0;
  assign lsu_load_data_o = (out_en && (state_q == S_RSP) &&  owner_q) ? mem_rdata_i : '0;

  // Memory side: request fields come straight from the capture registers.
  assign req_active  = out_en && (state_q == S_REQ);
  assign mem_req_o   = req_active;
  assign mem_we_o    = req_active && we_q;
  assign mem_adr_o   = req_active ? adr_q   : '0;
  assign mem_be_o    = req_active ? be_q    : '0;
  assign mem_wdata_o = req_active ? wdata_q : '0;

  // Lane steering for the LSU: byte enables from size/offset, store data replicated across lanes.
  always_comb begin
    lsu_be    = '1;
    lsu_wdata = lsu_store_data_i;
    if (lsu_access_size_i == 3'b001) begin
      lsu_be    = BE_BYTE << lsu_adr_i[AB-1:0];
      lsu_wdata = {NB{lsu_store_data_i[7:0]}};
    end else if (lsu_access_size_i == 3'b010) begin
      lsu_be    = BE_HALF << lsu_adr_i[AB-1:0];
      lsu_wdata = {(NB/2){lsu_store_data_i[15:0]}};
    end
  end

  // Next-state: FSM transitions, request capture, starvation counter and flush drop flag.
  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    starve_d = starve_q;
    drop_d   = drop_q;
    adr_d    = adr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    we_d     = we_q;

    case (state_q)
      S_IDLE: begin
        if (lsu_win || if_win) state_d = S_REQ;
      end
      S_REQ: begin
        if (mem_gnt_i) state_d = S_RSP;
      end
      S_RSP: begin
        if (mem_rvalid_i) state_d = (lsu_win || if_win) ? S_REQ : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (lsu_win) begin
      owner_d = 1'b1;
      adr_d   = word_adr(lsu_adr_i);
      be_d    = lsu_be;
      we_d    = lsu_is_store_i;
      wdata_d = lsu_is_store_i ? lsu_wdata : '0;
    end else if (if_win) begin
      owner_d = 1'b0;
      adr_d   = word_adr(if_adr_i);
      be_d    = '1;
      we_d    = 1'b0;
      wdata_d = '0;
    end

    if (!if_req_i || if_win) begin
      starve_d = 4'd0;
    end else if (lsu_win && if_ok && (starve_q != STARVE_MAX)) begin
      starve_d = starve_q + 4'd1;
    end

    if ((state_q == S_RSP) && mem_rvalid_i) begin
      drop_d = 1'b0;
    end else if (flush_i && !owner_q && (state_q != S_IDLE)) begin
      drop_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      owner_q  <= 1'b0;
      starve_q <= 4'd0;
      drop_q   <= 1'b0;
      live_q   <= 1'b0;
      adr_q    <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      starve_q <= starve_d;
      drop_q   <= drop_d;
      live_q   <= 1'b1;
      adr_q    <= adr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      we_q     <= we_d;
    end
  end

endmodule
